// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for a shared adder/subtractor.
// Stage 1 registers the granted operands; stage 2 registers result and flags.

module adder_sub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             alufn_i,
  output logic [WIDTH-1:0] result_o,
  output logic             z_o,
  output logic             v_o,
  output logic             n_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_full;

  // Subtract is A + ~B + 1, so carry-out 1 means "no borrow".
  assign b_eff    = alufn_i ? ~b_i : b_i;
  assign sum_full = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, alufn_i};

  assign result_o = sum_full[WIDTH-1:0];
  assign cout_o   = sum_full[WIDTH];
  assign z_o      = (sum_full[WIDTH-1:0] == '0);
  assign n_o      = sum_full[WIDTH-1];
  assign v_o      = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum_full[WIDTH-1] != a_i[WIDTH-1]);

endmodule

module addsub_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_alufn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_alufn,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_z,
  output logic             rsp_v,
  output logic             rsp_n,
  output logic             rsp_cout
);

  logic             grant0, grant1, transfer;
  logic             last_grant_q, last_grant_d;

  logic             s1_valid_q;
  logic             s1_owner_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s1_alufn_q;

  logic             s2_valid_q;
  logic             s2_owner_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_z_q, rsp_v_q, rsp_n_q, rsp_cout_q;

  logic [WIDTH-1:0] alu_result;
  logic             alu_z, alu_v, alu_n, alu_cout;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    grant0       = 1'b0;
    grant1       = 1'b0;
    last_grant_d = last_grant_q;
    if (!stall) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
    if (grant0) last_grant_d = 1'b0;
    if (grant1) last_grant_d = 1'b1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign transfer   = grant0 | grant1;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      rsp_result_q <= '0;
      rsp_z_q      <= 1'b0;
      rsp_v_q      <= 1'b0;
      rsp_n_q      <= 1'b0;
      rsp_cout_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      if (!stall) begin
        s1_valid_q   <= transfer;
        s2_valid_q   <= s1_valid_q;
        rsp_result_q <= alu_result;
        rsp_z_q      <= alu_z;
        rsp_v_q      <= alu_v;
        rsp_n_q      <= alu_n;
        rsp_cout_q   <= alu_cout;
      end
    end
  end

  // NOTE: operand and owner registers carry no reset; the valid bits alone
  // decide whether their contents are ever observed.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (transfer) begin
        s1_owner_q <= grant1;
        s1_a_q     <= grant1 ? req1_a     : req0_a;
        s1_b_q     <= grant1 ? req1_b     : req0_b;
        s1_alufn_q <= grant1 ? req1_alufn : req0_alufn;
      end
      s2_owner_q <= s1_owner_q;
    end
  end

  adder_sub #(.WIDTH(WIDTH)) u_adder_sub (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .alufn_i  (s1_alufn_q),
    .result_o (alu_result),
    .z_o      (alu_z),
    .v_o      (alu_v),
    .n_o      (alu_n),
    .cout_o   (alu_cout)
  );

  assign rsp0_valid = s2_valid_q & ~s2_owner_q;
  assign rsp1_valid = s2_valid_q &  s2_owner_q;
  assign rsp_result = rsp_result_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_v      = rsp_v_q;
  assign rsp_n      = rsp_n_q;
  assign rsp_cout   = rsp_cout_q;

endmodule
